// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two word requesters, the arbiter and the byte-wide data RAM.
// The slave side belongs to the arbiter; the master side is the requesters plus the RAM.
interface data_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        vga_req;
  logic [7:0]  vga_addr;
  logic        vga_ack;
  logic [31:0] vga_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_rdata,
    output cpu_ack, cpu_rdata, vga_ack, vga_rdata, ram_addr, ram_we, ram_wdata, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_rdata,
    input  cpu_ack, cpu_rdata, vga_ack, vga_rdata, ram_addr, ram_we, ram_wdata, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (read/write) and VGA (read-only) 32-bit word requests onto one
// 256x8 RAM port; each word is four big-endian byte accesses with registered RAM outputs.
module data_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;      // 1 = VGA owns the transfer
  logic        we_q, we_d;
  logic [7:0]  base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] vga_rdata_q, vga_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vga_ack_q, vga_ack_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        grant_vga;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    shadow_d    = shadow_q;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    cpu_ack_d   = 1'b0;
    vga_ack_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    grant_vga   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.vga_req) begin
          // CPU has priority unless VGA has been passed over STARVE_LIMIT times
          grant_vga = bus.vga_req && (!bus.cpu_req || starve_q == LIMIT);
          if (grant_vga)
            starve_d = 4'd0;
          else if (bus.vga_req && starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
          owner_d     = grant_vga;
          base_d      = grant_vga ? bus.vga_addr : bus.cpu_addr;
          we_d        = !grant_vga && bus.cpu_we;
          wdata_d     = bus.cpu_wdata;
          cnt_d       = 2'd0;
          ram_addr_d  = base_d;
          ram_we_d    = we_d;
          ram_wdata_d = bus.cpu_wdata[31:24];
          state_d     = XFER;
        end
      end
      XFER: begin
        if (!we_q) begin
          case (cnt_q)
            2'd0:    shadow_d[31:24] = bus.ram_rdata;
            2'd1:    shadow_d[23:16] = bus.ram_rdata;
            2'd2:    shadow_d[15:8]  = bus.ram_rdata;
            default: shadow_d[7:0]   = bus.ram_rdata;
          endcase
        end
        if (cnt_q == 2'd3) begin
          state_d   = DONE;
          cpu_ack_d = !owner_q;
          vga_ack_d = owner_q;
          if (!we_q) begin
            if (owner_q) vga_rdata_d = shadow_d;
            else         cpu_rdata_d = shadow_d;
          end
        end else begin
          cnt_d       = cnt_q + 2'd1;
          ram_addr_d  = base_q + {6'd0, cnt_d};
          ram_we_d    = we_q;
          ram_wdata_d = byte_of(wdata_q, cnt_d);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      starve_q    <= 4'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= 8'd0;
      wdata_q     <= 32'd0;
      shadow_q    <= 32'd0;
      cpu_rdata_q <= 32'd0;
      vga_rdata_q <= 32'd0;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
      ram_addr_q  <= 8'd0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vga_ack_q   <= vga_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.vga_ack   = vga_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vga_rdata = vga_rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a transaction-timeline reference model checks every cycle,
// driven by a directed vector table, hand-written corner sequences and random traffic.
module tb_data_mem_arbiter;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  data_mem_arbiter_if bus();

  data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ram_mem [256];
  logic [7:0] mem_ref [256];
  assign bus.ram_rdata = ram_mem[bus.ram_addr];

  typedef struct {
    bit          vga;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [6];

  int n_vec = 0;
  int n_bad = 0;
  int e = 0;
  // reference model: a transfer granted at edge g_edge shows byte k after edge g_edge+k, ack after g_edge+4
  int          g_edge = -100;
  bit          g_vga, g_we;
  logic [7:0]  g_addr;
  logic [31:0] g_wdata, g_word;
  int          starve_m = 0;
  logic [31:0] exp_cpu_rd = 0, exp_vga_rd = 0;
  bit          pend_we = 0;
  logic [7:0]  pend_addr, pend_wd;
  bit          saw_cpu, saw_vga;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'(w >> (8 * (3 - k)));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, got, exp, e);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got no event, expected one (edge %0d)", name, e);
  endtask

  task automatic tick();
    int d;
    bit rst_seen, xfer, done;
    @(posedge clk);
    e++;
    rst_seen = !rst_n;
    d = e - 1 - g_edge;
    if (d >= 0 && d <= 3 && g_we) mem_ref[8'(g_addr + d)] = byte_of(g_wdata, d);
    if (rst_seen) begin
      g_edge = -100; starve_m = 0; exp_cpu_rd = 0; exp_vga_rd = 0;
    end else begin
      if (e >= g_edge + 6 && (bus.cpu_req || bus.vga_req)) begin
        g_vga = bus.vga_req && (!bus.cpu_req || starve_m == LIMIT);
        if (g_vga) starve_m = 0;
        else if (bus.vga_req && starve_m < LIMIT) starve_m++;
        g_we    = !g_vga && bus.cpu_we;
        g_addr  = g_vga ? bus.vga_addr : bus.cpu_addr;
        g_wdata = bus.cpu_wdata;
        g_word  = {mem_ref[g_addr], mem_ref[8'(g_addr + 1)], mem_ref[8'(g_addr + 2)], mem_ref[8'(g_addr + 3)]};
        g_edge  = e;
      end
      if (e - g_edge == 4 && !g_we) begin
        if (g_vga) exp_vga_rd = g_word;
        else       exp_cpu_rd = g_word;
      end
    end
    #1;
    if (pend_we) ram_mem[pend_addr] = pend_wd;
    pend_we = bus.ram_we; pend_addr = bus.ram_addr; pend_wd = bus.ram_wdata;
    saw_cpu = bus.cpu_ack; saw_vga = bus.vga_ack;
    d = e - g_edge;
    xfer = (d >= 0 && d <= 3);
    done = (d == 4);
    check("busy", bus.busy, xfer || done);
    check("cpu_ack", bus.cpu_ack, done && !g_vga);
    check("vga_ack", bus.vga_ack, done && g_vga);
    check("ram_we", bus.ram_we, xfer ? g_we : 1'b0);
    if (xfer) begin
      check("ram_addr", bus.ram_addr, 8'(g_addr + d));
      if (g_we) check("ram_wdata", bus.ram_wdata, byte_of(g_wdata, d));
    end
    check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
    check("vga_rdata", bus.vga_rdata, exp_vga_rd);
    if (rst_seen) begin
      check("reset ram_addr", bus.ram_addr, 8'h00);
      check("reset ram_wdata", bus.ram_wdata, 8'h00);
    end
  endtask

  task automatic wait_ack(input bit vga, input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!(vga ? saw_vga : saw_cpu) && n < budget);
    if (!(vga ? saw_vga : saw_cpu)) fail_now(vga ? "vga ack timeout" : "cpu ack timeout");
  endtask

  task automatic wait_any(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!(saw_vga || saw_cpu) && n < budget);
    if (!(saw_vga || saw_cpu)) fail_now("any ack timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n, n1, n2;
    logic [7:0] b22, b23;
    bit cpu_pend, vga_pend;

    rst_n = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.vga_req = 0; bus.vga_addr = 0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      mem_ref[i] = 8'(i * 7 + 3);
    end
    ram_mem[8'hFE] = 8'h11; ram_mem[8'hFF] = 8'h22; ram_mem[8'h00] = 8'h33; ram_mem[8'h01] = 8'h44;
    mem_ref[8'hFE] = 8'h11; mem_ref[8'hFF] = 8'h22; mem_ref[8'h00] = 8'h33; mem_ref[8'h01] = 8'h44;

    tbl[0] = '{vga: 0, we: 1, addr: 8'h10, wdata: 32'hDEADBEEF, exp_rd: 32'h0};
    tbl[1] = '{vga: 0, we: 0, addr: 8'h10, wdata: 32'h0,        exp_rd: 32'hDEADBEEF};
    tbl[2] = '{vga: 1, we: 0, addr: 8'hFE, wdata: 32'h0,        exp_rd: 32'h11223344};
    tbl[3] = '{vga: 0, we: 1, addr: 8'hFD, wdata: 32'h01020304, exp_rd: 32'h0};
    tbl[4] = '{vga: 1, we: 0, addr: 8'hFD, wdata: 32'h0,        exp_rd: 32'h01020304};
    tbl[5] = '{vga: 0, we: 0, addr: 8'hFE, wdata: 32'h0,        exp_rd: 32'h02030444};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].vga) begin
        bus.vga_req = 1; bus.vga_addr = tbl[i].addr;
      end else begin
        bus.cpu_req = 1; bus.cpu_we = tbl[i].we; bus.cpu_addr = tbl[i].addr; bus.cpu_wdata = tbl[i].wdata;
      end
      wait_ack(tbl[i].vga, 20, n);
      check($sformatf("vec%0d latency", i), n, 5);
      if (!tbl[i].we) check($sformatf("vec%0d rdata", i), tbl[i].vga ? bus.vga_rdata : bus.cpu_rdata, tbl[i].exp_rd);
      bus.cpu_req = 0; bus.vga_req = 0;
      tick(); tick();
    end

    // both requesters held high: three CPU grants then one VGA, repeating
    do_reset();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h40;
    bus.vga_req = 1; bus.vga_addr = 8'h80;
    for (int k = 0; k < 8; k++) begin
      wait_any(12, n);
      check($sformatf("grant%0d is vga", k), saw_vga, (k % 4) == 3);
      check($sformatf("grant%0d spacing", k), n, (k == 0) ? 5 : 6);
    end
    bus.cpu_req = 0; bus.vga_req = 0;
    tick(); tick();

    // reset lands as the write would enter its third byte
    b22 = ram_mem[8'h22]; b23 = ram_mem[8'h23];
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 32'hA1B2C3D4;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    bus.cpu_req = 0; rst_n = 1'b1;
    check("abort ram[20]", ram_mem[8'h20], 8'hA1);
    check("abort ram[21]", ram_mem[8'h21], 8'hB2);
    check("abort ram[22]", ram_mem[8'h22], b22);
    check("abort ram[23]", ram_mem[8'h23], b23);
    for (int i = 0; i < 6; i++) tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h20;
    wait_ack(1'b0, 20, n);
    check("post-abort latency", n, 5);
    check("post-abort rdata", bus.cpu_rdata, {8'hA1, 8'hB2, b22, b23});
    bus.cpu_req = 0;
    tick(); tick();

    // CPU request arrives while VGA is mid-transfer
    bus.vga_req = 1; bus.vga_addr = 8'h30;
    tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h34;
    wait_ack(1'b1, 12, n1);
    check("late vga ack", n1, 4);
    bus.vga_req = 0;
    wait_ack(1'b0, 12, n2);
    check("waiting cpu ack gap", n2, 6);
    bus.cpu_req = 0;
    tick(); tick();

    cpu_pend = 0; vga_pend = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (cpu_pend && saw_cpu) begin cpu_pend = 0; bus.cpu_req = 0; end
      if (vga_pend && saw_vga) begin vga_pend = 0; bus.vga_req = 0; end
      if (!cpu_pend && $urandom_range(0, 2) == 0) begin
        cpu_pend = 1; bus.cpu_req = 1; bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 8'($urandom); bus.cpu_wdata = $urandom;
      end
      if (!vga_pend && $urandom_range(0, 2) == 0) begin
        vga_pend = 1; bus.vga_req = 1; bus.vga_addr = 8'($urandom);
      end
    end
    bus.cpu_req = 0; bus.vga_req = 0;
    for (int i = 0; i < 14; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
